// File: rtl/interlayer_buffer_reader.sv
// Read-side engine for the interlayer feature-map RAM. It walks the stored
// maps row-outer / feature-inner, issues one row of reads at a time, and
// hands each assembled row to the next layer with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | issuing INPUT_SIZE sequential RAM reads for the current row
// FLUSH | no read; last word of the row lands in the row register
// OUT   | row presented on data_o, held until ready_i
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module interlayer_buffer_reader #(
  parameter int BUFFER_DEPTH  = 4096,
  parameter int INPUT_SIZE    = 12,
  parameter int TOTAL_FEATURE = 20,
  parameter int DATA_WIDTH    = `DATA_WIDTH,
  localparam int ADDR_WIDTH    = $clog2(BUFFER_DEPTH),
  localparam int FEATURE_WIDTH = $clog2(TOTAL_FEATURE),
  localparam int ROW_WIDTH     = $clog2(INPUT_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic                             ram_re_o,
  input  logic [DATA_WIDTH-1:0]            ram_data_i,
  output logic [INPUT_SIZE*DATA_WIDTH-1:0] data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [FEATURE_WIDTH-1:0]         feature_idx_o,
  output logic [ROW_WIDTH-1:0]             feature_row_o,
  output logic                             busy_o,
  output logic                             done_o
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, OUT} state_t;

  localparam logic [ROW_WIDTH-1:0]     LAST_IDX  = ROW_WIDTH'(INPUT_SIZE - 1);
  localparam logic [FEATURE_WIDTH-1:0] LAST_FEAT = FEATURE_WIDTH'(TOTAL_FEATURE - 1);
  localparam logic [ADDR_WIDTH-1:0]    ROW_STEP  = ADDR_WIDTH'(INPUT_SIZE);
  localparam logic [ADDR_WIDTH-1:0]    CH_STEP   = ADDR_WIDTH'(INPUT_SIZE * INPUT_SIZE);

  state_t                          state_q, state_d;
  logic [ROW_WIDTH-1:0]            col_q, col_d;
  logic [ROW_WIDTH-1:0]            row_q, row_d;
  logic [FEATURE_WIDTH-1:0]        feat_q, feat_d;
  logic [ADDR_WIDTH-1:0]           ch_bias_q, ch_bias_d;
  logic [ADDR_WIDTH-1:0]           row_bias_q, row_bias_d;
  logic                            done_q, done_d;
  logic                            cap_en_q;
  logic [ROW_WIDTH-1:0]            col_dly_q;
  logic [INPUT_SIZE*DATA_WIDTH-1:0] row_data_q;
  logic                            re;

  // Walk control: next state, counters and bias registers.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    feat_d     = feat_q;
    ch_bias_d  = ch_bias_q;
    row_bias_d = row_bias_q;
    done_d     = 1'b0;
    re         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = READ;
          col_d      = '0;
          row_d      = '0;
          feat_d     = '0;
          ch_bias_d  = '0;
          row_bias_d = '0;
        end
      end
      READ: begin
        re    = 1'b1;
        col_d = col_q + 1'b1;
        if (col_q == LAST_IDX) state_d = FLUSH;
      end
      FLUSH: state_d = OUT;
      OUT: begin
        if (ready_i) begin
          col_d = '0;
          if (feat_q == LAST_FEAT && row_q == LAST_IDX) begin
            done_d     = 1'b1;
            state_d    = IDLE;
            ch_bias_d  = '0;
            row_bias_d = '0;
          end else if (feat_q == LAST_FEAT) begin
            feat_d     = '0;
            ch_bias_d  = '0;
            row_d      = row_q + 1'b1;
            row_bias_d = row_bias_q + ROW_STEP;
            state_d    = READ;
          end else begin
            feat_d    = feat_q + 1'b1;
            ch_bias_d = ch_bias_q + CH_STEP;
            state_d   = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and bias registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      feat_q     <= '0;
      ch_bias_q  <= '0;
      row_bias_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      feat_q     <= feat_d;
      ch_bias_q  <= ch_bias_d;
      row_bias_q <= row_bias_d;
      done_q     <= done_d;
    end
  end

  // RAM data arrives one cycle after its address, so the column and the
  // read strobe are delayed to steer it into the right slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en_q   <= 1'b0;
      col_dly_q  <= '0;
      row_data_q <= '0;
    end else begin
      cap_en_q  <= re;
      col_dly_q <= col_q;
      if (cap_en_q) begin
        for (int c = 0; c < INPUT_SIZE; c++) begin
          if (int'(col_dly_q) == c)
            row_data_q[(INPUT_SIZE-c)*DATA_WIDTH-1 -: DATA_WIDTH] <= ram_data_i;
        end
      end
    end
  end

  assign ram_re_o      = re;
  assign ram_addr_o    = re ? (ch_bias_q + row_bias_q + ADDR_WIDTH'(col_q)) : '0;
  assign data_o        = row_data_q;
  assign valid_o       = (state_q == OUT);
  assign feature_idx_o = feat_q;
  assign feature_row_o = row_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

endmodule

// File: tb/tb_interlayer_buffer_reader.sv
// Bench for interlayer_buffer_reader: RAM holds word = address; a
// walk-order model predicts every read address, every delivered row,
// busy and done, with directed timing checks on top.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_interlayer_buffer_reader;
  localparam int N   = 12;
  localparam int NF  = 20;
  localparam int DW  = `DATA_WIDTH;
  localparam int ROWS = N * NF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              ready_i = 1'b0;
  logic [11:0]       ram_addr_o;
  logic              ram_re_o;
  logic [DW-1:0]     ram_data_i = '0;
  logic [N*DW-1:0]   data_o;
  logic              valid_o;
  logic [4:0]        feature_idx_o;
  logic [3:0]        feature_row_o;
  logic              busy_o;
  logic              done_o;

  int checks = 0;
  int failures = 0;

  interlayer_buffer_reader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .ram_addr_o(ram_addr_o), .ram_re_o(ram_re_o), .ram_data_i(ram_data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .feature_idx_o(feature_idx_o), .feature_row_o(feature_row_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // RAM model: word = address, registered read.
  always @(posedge clk) if (ram_re_o) ram_data_i <= DW'(ram_addr_o);

  task automatic check(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Walk order: row index k -> row r = k / NF, feature f = k % NF.
  function automatic int word_addr(input int k, input int c);
    return (k % NF) * N * N + (k / NF) * N + c;
  endfunction

  function automatic logic [N*DW-1:0] row_word(input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[(N-c)*DW-1 -: DW] = DW'(word_addr(k, c));
    return v;
  endfunction

  // Behavioural model and per-cycle compare.
  int rd_idx = 0, hs_idx = 0, walks = 0;
  bit active = 0, exp_done = 0, prev_valid = 0, prev_hs = 0;
  logic [N*DW-1:0] prev_data;
  logic [4:0] prev_f;
  logic [3:0] prev_r;

  always @(negedge clk) begin
    bit was_active, hs;
    if (!rst_n) begin
      rd_idx = 0; hs_idx = 0; active = 0; exp_done = 0;
      prev_valid = 0; prev_hs = 0;
    end else begin
      check("done_o", done_o, exp_done);
      check("busy_o", busy_o, active);
      exp_done = 0;
      was_active = active;
      if (ram_re_o) begin
        check("re_vs_valid", valid_o, 1'b0);
        check("ram_addr", ram_addr_o, word_addr(rd_idx / N, rd_idx % N));
        rd_idx++;
      end
      if (valid_o) begin
        check("reads_before_row", rd_idx, (hs_idx + 1) * N);
        if (prev_valid && !prev_hs) begin
          check("hold_data", data_o, prev_data);
          check("hold_feat", feature_idx_o, prev_f);
          check("hold_row", feature_row_o, prev_r);
        end
      end
      hs = valid_o && ready_i;
      if (hs) begin
        check("row_data", data_o, row_word(hs_idx));
        check("row_feat", feature_idx_o, hs_idx % NF);
        check("row_idx", feature_row_o, hs_idx / NF);
        hs_idx++;
        if (hs_idx == ROWS) begin
          exp_done = 1; active = 0; hs_idx = 0; rd_idx = 0; walks++;
        end
      end
      if (!was_active && start_i) active = 1;
      prev_valid = valid_o; prev_hs = hs;
      prev_data = data_o; prev_f = feature_idx_o; prev_r = feature_row_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  ram_addr_o, 0);
    check({tag, "_re"},    ram_re_o, 0);
    check({tag, "_data"},  data_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_feat"},  feature_idx_o, 0);
    check({tag, "_row"},   feature_row_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_done"},  done_o, 0);
  endtask

  initial begin
    int cyc;
    int dones;
    logic [N*DW-1:0] lit;

    // Reset state
    #1;
    check_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Full walk with ready high, directed timing and a start while busy
    ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 1;
    dones = 0;
    check("t1_re", ram_re_o, 1);
    check("t1_addr", ram_addr_o, 0);
    while (!done_o && cyc < 4000) begin
      tick();
      cyc++;
      start_i = (cyc == 73);
      if (cyc == 12) check("t12_addr", ram_addr_o, 11);
      if (cyc == 13) begin
        check("t13_re", ram_re_o, 0);
        check("t13_valid", valid_o, 0);
      end
      if (cyc == 14) begin
        for (int c = 0; c < N; c++) lit[(N-c)*DW-1 -: DW] = DW'(c);
        check("t14_valid", valid_o, 1);
        check("t14_data", data_o, lit);
        check("t14_feat", feature_idx_o, 0);
        check("t14_row", feature_row_o, 0);
      end
      if (cyc == 15) check("row1_addr", ram_addr_o, 144);
      if (cyc == 281) check("row20_addr", ram_addr_o, 12);
      if (cyc == 3360) begin
        check("last_valid", valid_o, 1);
        check("last_msb", data_o[N*DW-1 -: DW], 2868);
        check("last_lsb", data_o[DW-1:0], 2879);
        check("last_feat", feature_idx_o, 19);
        check("last_row", feature_row_o, 11);
      end
    end
    start_i = 1'b0;
    check("done_cycle", cyc, 3361);
    check("done_busy", busy_o, 0);
    tick();
    check("done_one_pulse", done_o, 0);

    // Backpressure, then random ready
    ready_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 0;
    while (!valid_o && cyc < 100) begin tick(); cyc++; end
    check("bp_valid_reached", valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", valid_o, 1);
      check("bp_re", ram_re_o, 0);
    end
    ready_i = 1'b1;
    tick();
    check("bp_resume_re", ram_re_o, 1);
    check("bp_resume_addr", ram_addr_o, 144);
    cyc = 0;
    while (!done_o && cyc < 20000) begin
      ready_i = ($urandom_range(0, 3) != 0);
      start_i = ($urandom_range(0, 199) == 0);
      tick();
      cyc++;
    end
    start_i = 1'b0;
    check("rand_done_reached", done_o, 1);

    // Reset mid-READ, then restart from address 0
    ready_i = 1'b1;
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_re", ram_re_o, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("restart_re", ram_re_o, 1);
    check("restart_addr", ram_addr_o, 0);
    cyc = 1;
    while (!done_o && cyc < 4000) begin tick(); cyc++; end
    check("restart_done_cycle", cyc, 3361);
    tick();

    check("walks_completed", walks, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
